// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned INSTR_W   = 14;
  localparam int unsigned LEN_W     = 11;

  typedef enum logic [3:0] {
    StIdle,
    StLenH,
    StLenL,
    StDatH,
    StDatL,
    StWr,
    StChk,
    StRun,
    StError
  } ld_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, program RAM write port and CPU control of the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 11
);
  import prog_loader_pkg::*;

  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [INSTR_W-1:0]  wr_data;
  logic                cpu_rst;
  logic                done;
  logic                err;

  // master: byte source / system side; slave: the loader
  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  cpu_rst,
    input  done,
    input  err
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output cpu_rst,
    output done,
    output err
  );

endinterface

// File: rtl/prog_loader.sv
// Framed serial program loader: parses SYNC/LEN/DATA/CHK frames, writes 14-bit
// words into program RAM and releases the CPU only after a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic         i_clk,
  input  logic         i_rst,
  prog_loader_if.slave io_bus
);

  ld_state_e            r_state;
  ld_state_e            w_state_d;
  logic [ADDR_W-1:0]    r_wcnt;
  logic [ADDR_W-1:0]    w_wcnt_d;
  logic [ADDR_W:0]      w_wcnt_inc;
  logic [7:0]           r_sum;
  logic [7:0]           w_sum_d;
  logic [7:0]           w_sum_add;
  logic [2:0]           r_len_h;
  logic [7:0]           r_len_l;
  logic [5:0]           r_dat_h;
  logic [LEN_W-1:0]     w_len;
  logic                 w_last_word;
  logic                 w_xfer;
  logic                 w_is_sync;

  logic                 r_byte_ready;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [INSTR_W-1:0]   r_wr_data;
  logic                 r_cpu_rst;
  logic                 r_done;
  logic                 r_err;

  assign w_xfer      = io_bus.byte_valid && r_byte_ready;
  assign w_is_sync   = (io_bus.byte_data == SYNC);
  assign w_sum_add   = r_sum + io_bus.byte_data;
  assign w_len       = {r_len_h, r_len_l};
  assign w_wcnt_inc  = {1'b0, r_wcnt} + 1'b1;
  assign w_last_word = (w_wcnt_inc == (ADDR_W + 1)'(w_len));

  always_comb begin
    w_state_d = r_state;
    w_wcnt_d  = r_wcnt;
    w_sum_d   = r_sum;
    unique case (r_state)
      StIdle, StRun, StError: begin
        if (w_xfer && w_is_sync) begin
          w_state_d = StLenH;
          w_wcnt_d  = '0;
          w_sum_d   = '0;
        end
      end
      StLenH: begin
        if (w_xfer) begin
          w_sum_d   = w_sum_add;
          w_state_d = (io_bus.byte_data[7:3] != 5'd0) ? StError : StLenL;
        end
      end
      StLenL: begin
        if (w_xfer) begin
          w_sum_d   = w_sum_add;
          w_state_d = ({r_len_h, io_bus.byte_data} == '0) ? StChk : StDatH;
        end
      end
      StDatH: begin
        if (w_xfer) begin
          w_sum_d   = w_sum_add;
          w_state_d = (io_bus.byte_data[7:6] != 2'd0) ? StError : StDatL;
        end
      end
      StDatL: begin
        if (w_xfer) begin
          w_sum_d   = w_sum_add;
          w_state_d = StWr;
        end
      end
      StWr: begin
        w_wcnt_d  = w_wcnt_inc[ADDR_W-1:0];
        w_state_d = w_last_word ? StChk : StDatH;
      end
      StChk: begin
        if (w_xfer) begin
          w_state_d = (w_sum_add == 8'h00) ? StRun : StError;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Status outputs are decoded from the next state so they change on the accepting edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_wcnt       <= '0;
      r_sum        <= '0;
      r_len_h      <= '0;
      r_len_l      <= '0;
      r_dat_h      <= '0;
      r_byte_ready <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wcnt  <= w_wcnt_d;
      r_sum   <= w_sum_d;
      if (w_xfer && (r_state == StLenH)) r_len_h <= io_bus.byte_data[2:0];
      if (w_xfer && (r_state == StLenL)) r_len_l <= io_bus.byte_data;
      if (w_xfer && (r_state == StDatH)) r_dat_h <= io_bus.byte_data[5:0];
      if (w_state_d == StWr) begin
        r_wr_addr <= r_wcnt;
        r_wr_data <= {r_dat_h, io_bus.byte_data};
      end
      r_wr_en      <= (w_state_d == StWr);
      r_byte_ready <= (w_state_d != StWr);
      r_cpu_rst    <= (w_state_d != StRun);
      r_done       <= (w_state_d == StRun);
      r_err        <= (w_state_d == StError);
    end
  end

  assign io_bus.byte_ready = r_byte_ready;
  assign io_bus.wr_en      = r_wr_en;
  assign io_bus.wr_addr    = r_wr_addr;
  assign io_bus.wr_data    = r_wr_data;
  assign io_bus.cpu_rst    = r_cpu_rst;
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the soft PIC-style core. It is the write side of the program memory that the CPU fetches from. It receives a framed byte stream (from a UART receiver or debug bridge), assembles 14-bit instruction words, and writes them into an 11-bit-addressed program RAM. It holds the CPU in reset while loading and releases it only after a frame passes its checksum.

## Interface
- `ADDR_W`, 11: program memory address width; matches the CPU PC/MAR width.
- `SYNC`, 8'hA5: frame start byte.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_data` in 8: incoming byte.
- `byte_ready` out 1: the loader accepts a byte this cycle.
- `wr_en` out 1: program RAM write strobe.
- `wr_addr` out ADDR_W: program RAM write address.
- `wr_data` out 14: instruction word.
- `cpu_rst` out 1: reset to the CPU core; high while not running.
- `done` out 1: a valid program is loaded and the CPU is running.
- `err` out 1: the last frame was rejected.

## Operation
- Frame format: `SYNC`, LEN_H, LEN_L, then N × (DAT_H, DAT_L), then CHK.
  - N = {LEN_H[2:0], LEN_L}.
  - Word = {DAT_H[5:0], DAT_L}.
- A byte transfers on a rising edge with `byte_valid && byte_ready`.
- States:
  - IDLE: discard bytes ≠ `SYNC`. On `SYNC`, clear the sum and `wcnt`, then go to LEN_H.
  - LEN_H: if byte[7:3] ≠ 0, go to ERROR. Otherwise latch it and go to LEN_L.
  - LEN_L: latch it. If N = 0, go to CHK; otherwise go to DAT_H.
  - DAT_H: if byte[7:6] ≠ 0, go to ERROR. Otherwise latch it and go to DAT_L.
  - DAT_L: latch it and go to WR.
  - WR: one cycle. `wr_en` = 1, `wr_addr` = `wcnt`, `wr_data` = assembled word, `byte_ready` = 0. Then `wcnt` increments. If `wcnt` + 1 = N, go to CHK; otherwise go to DAT_H.
  - CHK: if (sum + byte) mod 256 = 0, go to RUN; otherwise go to ERROR.
  - RUN: `done` = 1 and `cpu_rst` = 0. A `SYNC` byte restarts loading: go to LEN_H, and `cpu_rst` rises on the same edge. Other bytes are discarded.
  - ERROR: `err` = 1. `SYNC` goes to LEN_H and clears `err`. Other bytes are discarded.
- Checksum: sum is the 8-bit wrapping sum of every byte after `SYNC` and before CHK, i.e. LEN_H, LEN_L and all data bytes.
- `byte_ready` = 1 in every state except WR.
- `cpu_rst`, `done` and `err` are registered, decoded from the next state.
- A write is never issued for a word whose DAT_L did not arrive.
- On ERROR, words already written stay in RAM. The CPU is not released.
- `rst` in any state:
  - state goes to IDLE;
  - `wcnt` and the sum are cleared;
  - outputs take their reset values;
  - no `wr_en` pulse is issued on the reset edge.

## Timing
- Reset values: `byte_ready` = 1, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `cpu_rst` = 1, `done` = 0, `err` = 0.
- `wr_en` is high exactly one cycle, the cycle after DAT_L is accepted.
- `wr_addr` and `wr_data` are stable while `wr_en` is high. They hold their last value otherwise.
- Back-to-back bytes: one byte per cycle, except the WR bubble. A source holding `byte_valid` through WR has its byte accepted on the following cycle.
- `cpu_rst` falls and `done` rises in the cycle after the CHK byte is accepted. The CPU first fetches address 0 on the next cycle.
- `err` rises in the cycle after the offending byte is accepted.
- Worst-case frame: N = 2047, giving 4 + 3·2047 cycles with continuous input.

## Structure
- The shared package `prog_loader_pkg` holds:
  - the state enum `ld_state_e` (IDLE, LEN_H, LEN_L, DAT_H, DAT_L, WR, CHK, RUN, ERROR);
  - `SYNC_BYTE`;
  - `INSTR_W` = 14.
- No sub-module. The block is a single FSM plus the counter, sum and data registers.
- The program RAM itself is outside this block.

## Test plan
- Basic load: A5 00 02 30 05 00 8D 3C →
  - `wr_en` at address 0 with data 14'h3005, then address 1 with 14'h008D;
  - `cpu_rst` 1→0 and `done` = 1 one cycle after 3C.
- Bad checksum: the same frame with CHK = 3D → no state change to RUN, `err` = 1, `cpu_rst` stays 1, `done` = 0.
- Resync and empty frame:
  - 00 FF 12 followed by the basic frame → identical writes to the basic load;
  - separately, A5 00 00 00 → `done` = 1 with zero writes.
- Format errors:
  - DAT_H = 0x40 → `err` = 1 the next cycle, no write for that word;
  - LEN_H = 0x08 → `err` = 1.
- Reset mid-frame: assert `rst` after the first word is written →
  - IDLE, `cpu_rst` = 1;
  - a subsequent full frame writes starting again at address 0.
- Backpressure and reload:
  - `byte_valid` held high continuously → `byte_ready` = 0 exactly in WR cycles, and no byte is lost or duplicated;
  - in RUN, sending A5 → `cpu_rst` = 1 and `done` = 0 the next cycle.
